// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues data-cache requests, stalls until the cache
// responds, and owns the MEM/WB pipeline register feeding writeback.
package mem_stage_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] load_type;  // funct3: [1:0] = access size, [2] = unsigned load
        logic       reg_write;
        logic [4:0] rd;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs2;
    } stage_regs;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int width = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  stage_regs          regs_in,
    input  logic               stall_in,
    input  logic [width-1:0]   dcache_rdata,
    input  logic               dcache_resp,
    output logic               dcache_read,
    output logic               dcache_write,
    output logic [width-1:0]   dcache_address,
    output logic [width-1:0]   dcache_wdata,
    output logic [3:0]         dcache_byte_enable,
    output logic               mem_stall,
    output stage_regs          regs_out,
    output logic [width-1:0]   dcache_out,
    output logic               misaligned
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state, next_state;
    logic               op;
    logic               aligned;
    logic               misalign;
    logic               advance;
    logic [1:0]         offset;
    logic [1:0]         size;
    logic [width-1:0]   hold_data;
    logic [width-1:0]   load_word;

    assign op      = regs_in.ctrl.mem_read | regs_in.ctrl.mem_write;
    assign offset  = regs_in.alu[1:0];
    assign size    = regs_in.ctrl.load_type[1:0];

    always_comb begin
        aligned = 1'b1;
        if (size == SIZE_HALF) begin
            aligned = ~offset[0];
        end else if (size != SIZE_BYTE) begin
            aligned = (offset == 2'b00);
        end
    end

    assign misalign       = op & ~aligned;
    assign dcache_address = {regs_in.alu[width-1:2], 2'b00};

    // Store lane steering: loads always read the whole word.
    always_comb begin
        dcache_byte_enable = 4'b1111;
        dcache_wdata       = '0;
        if (regs_in.ctrl.mem_write) begin
            if (size == SIZE_BYTE) begin
                dcache_byte_enable = 4'b0001 << offset;
                dcache_wdata       = regs_in.rs2 << {offset, 3'b000};
            end else if (size == SIZE_HALF) begin
                dcache_byte_enable = 4'b0011 << offset;
                dcache_wdata       = regs_in.rs2 << {offset, 3'b000};
            end else begin
                dcache_wdata       = regs_in.rs2;
            end
        end
    end

    // HOLD parks a completed access while the rest of the pipe is stalled, so
    // the request is never reissued to the cache.
    always_comb begin
        next_state   = state;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        mem_stall    = 1'b0;
        unique case (state)
            IDLE: begin
                if (op && aligned && !rst) begin
                    dcache_read  = regs_in.ctrl.mem_read;
                    dcache_write = regs_in.ctrl.mem_write;
                    mem_stall    = ~dcache_resp;
                    if (dcache_resp && stall_in) begin
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall_in) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign advance = ~stall_in & ~mem_stall;

    always_comb begin
        load_word = '0;
        if (regs_in.ctrl.mem_read && !misalign) begin
            load_word = (state == HOLD) ? hold_data : dcache_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && next_state == HOLD) begin
            hold_data <= dcache_rdata;
        end
    end

    // MEM/WB boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_out   <= '0;
            dcache_out <= '0;
            misaligned <= 1'b0;
        end else if (advance) begin
            regs_out   <= regs_in;
            dcache_out <= load_word;
            misaligned <= misalign;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected MEM/WB contents into a
// queue, a monitor pops and compares whenever a new instruction lands in MEM/WB.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    stage_regs   regs_in;
    logic        stall_in = 1'b0;
    logic [31:0] dcache_rdata = '0;
    logic        dcache_resp = 1'b0;
    logic        dcache_read, dcache_write;
    logic [31:0] dcache_address, dcache_wdata;
    logic [3:0]  dcache_byte_enable;
    logic        mem_stall;
    stage_regs   regs_out;
    logic [31:0] dcache_out;
    logic        misaligned;

    typedef struct {
        stage_regs   r;
        logic [31:0] d;
        logic        m;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.width(32)) dut (
        .clk(clk), .rst(rst), .regs_in(regs_in), .stall_in(stall_in),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_byte_enable(dcache_byte_enable), .mem_stall(mem_stall),
        .regs_out(regs_out), .dcache_out(dcache_out), .misaligned(misaligned)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic stage_regs mk(input logic [31:0] pc, input logic mr, input logic mw,
                                     input logic [2:0] lt, input logic [31:0] alu,
                                     input logic [31:0] rs2, input logic [4:0] rd);
        stage_regs s;
        s.ctrl.mem_read  = mr;
        s.ctrl.mem_write = mw;
        s.ctrl.load_type = lt;
        s.ctrl.reg_write = mr | (~mr & ~mw);
        s.ctrl.rd        = rd;
        s.pc             = pc;
        s.alu            = alu;
        s.rs2            = rs2;
        return s;
    endfunction

    task automatic push(input stage_regs r, input logic [31:0] d, input logic m);
        exp_t e;
        e.r = r;
        e.d = d;
        e.m = m;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a change of regs_out.pc marks a new instruction in MEM/WB.
    initial begin
        logic [31:0] last_pc;
        exp_t        e;
        last_pc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_pc = '0;
            end else if (regs_out.pc != last_pc) begin
                last_pc = regs_out.pc;
                if (last_pc != 0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_wb: got pc %h expected no instruction", last_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_regs", 128'(regs_out), 128'(e.r));
                        chk("wb_dcache_out", 128'(dcache_out), 128'(e.d));
                        chk("wb_misaligned", 128'(misaligned), 128'(e.m));
                    end
                end
            end
        end
    end

    initial begin
        stage_regs i;
        regs_in = '0;

        // Reset state
        @(negedge clk);
        chk("rst_regs_out", 128'(regs_out), 128'(0));
        chk("rst_dcache_out", 128'(dcache_out), 128'(0));
        chk("rst_misaligned", 128'(misaligned), 128'(0));
        chk("rst_read", 128'(dcache_read), 128'(0));
        cyc();
        rst = 1'b0;

        // Reset mid-load: request abandoned, late resp ignored
        cyc();
        regs_in = mk(32'h10, 1, 0, 3'b010, 32'h100, 0, 5'd1);
        @(negedge clk);
        chk("ml_read_before_rst", 128'(dcache_read), 128'(1));
        chk("ml_stall_before_rst", 128'(mem_stall), 128'(1));
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("ml_read_in_rst", 128'(dcache_read), 128'(0));
        chk("ml_regs_out_rst", 128'(regs_out), 128'(0));
        cyc();
        rst = 1'b0;
        regs_in = '0;
        dcache_resp = 1'b1;
        dcache_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("ml_late_resp_stall", 128'(mem_stall), 128'(0));
        chk("ml_late_resp_read", 128'(dcache_read), 128'(0));
        cyc();
        dcache_resp = 1'b0;
        @(negedge clk);
        chk("ml_regs_out_after", 128'(regs_out), 128'(0));

        // lw 0x1000, resp on the third cycle
        cyc();
        i = mk(32'h20, 1, 0, 3'b010, 32'h1000, 0, 5'd5);
        regs_in = i;
        push(i, 32'hDEADBEEF, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("lw_read_wait", 128'(dcache_read), 128'(1));
            chk("lw_stall_wait", 128'(mem_stall), 128'(1));
            chk("lw_address", 128'(dcache_address), 128'(32'h1000));
            cyc();
        end
        dcache_resp = 1'b1;
        dcache_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("lw_read_resp", 128'(dcache_read), 128'(1));
        chk("lw_stall_resp", 128'(mem_stall), 128'(0));

        // sb 0x2003, same-cycle resp
        cyc();
        dcache_rdata = 32'h0;
        i = mk(32'h30, 0, 1, 3'b000, 32'h2003, 32'h000000A5, 5'd0);
        regs_in = i;
        push(i, 32'h0, 1'b0);
        @(negedge clk);
        chk("sb_write", 128'(dcache_write), 128'(1));
        chk("sb_read", 128'(dcache_read), 128'(0));
        chk("sb_address", 128'(dcache_address), 128'(32'h2000));
        chk("sb_be", 128'(dcache_byte_enable), 128'(4'b1000));
        chk("sb_wdata", 128'(dcache_wdata), 128'(32'hA5000000));
        chk("sb_stall", 128'(mem_stall), 128'(0));

        // sh 0x2002
        cyc();
        i = mk(32'h40, 0, 1, 3'b001, 32'h2002, 32'h00001234, 5'd0);
        regs_in = i;
        push(i, 32'h0, 1'b0);
        @(negedge clk);
        chk("sh_be", 128'(dcache_byte_enable), 128'(4'b1100));
        chk("sh_wdata", 128'(dcache_wdata), 128'(32'h12340000));
        chk("sh_address", 128'(dcache_address), 128'(32'h2000));

        // Misaligned sw 0x3001
        cyc();
        dcache_resp = 1'b0;
        i = mk(32'h50, 0, 1, 3'b010, 32'h3001, 32'hCAFEF00D, 5'd0);
        regs_in = i;
        push(i, 32'h0, 1'b1);
        @(negedge clk);
        chk("msw_read", 128'(dcache_read), 128'(0));
        chk("msw_write", 128'(dcache_write), 128'(0));
        chk("msw_stall", 128'(mem_stall), 128'(0));

        // lw whose resp coincides with stall_in, held two cycles
        cyc();
        i = mk(32'h60, 1, 0, 3'b010, 32'h4000, 0, 5'd7);
        regs_in = i;
        stall_in = 1'b1;
        dcache_resp = 1'b1;
        dcache_rdata = 32'h55AA55AA;
        push(i, 32'h55AA55AA, 1'b0);
        @(negedge clk);
        chk("hold_read_resp", 128'(dcache_read), 128'(1));
        chk("hold_stall_resp", 128'(mem_stall), 128'(0));
        chk("hold_wb_frozen0", 128'(regs_out.pc), 128'(32'h50));
        cyc();
        dcache_resp = 1'b0;
        dcache_rdata = 32'h11111111;
        @(negedge clk);
        chk("hold_no_reissue", 128'(dcache_read), 128'(0));
        chk("hold_stall", 128'(mem_stall), 128'(0));
        chk("hold_wb_frozen1", 128'(regs_out.pc), 128'(32'h50));
        cyc();
        stall_in = 1'b0;
        @(negedge clk);
        chk("hold_release_read", 128'(dcache_read), 128'(0));

        // Misaligned lh 0x5003
        cyc();
        dcache_rdata = 32'h0;
        i = mk(32'h70, 1, 0, 3'b001, 32'h5003, 0, 5'd8);
        regs_in = i;
        push(i, 32'h0, 1'b1);
        @(negedge clk);
        chk("mlh_read", 128'(dcache_read), 128'(0));

        // Non-memory instruction held one cycle by stall_in
        cyc();
        i = mk(32'h80, 0, 0, 3'b000, 32'h12345678, 32'h9, 5'd9);
        regs_in = i;
        stall_in = 1'b1;
        push(i, 32'h0, 1'b0);
        @(negedge clk);
        chk("alu_stalled_wb", 128'(regs_out.pc), 128'(32'h70));
        cyc();
        stall_in = 1'b0;

        // Drain
        cyc();
        regs_in = '0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) cyc();
        @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
